// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
//   Shared types and constants for the SPI memory slave.
//   - state_e       : transaction state of the slave FSM
//   - CMD_*_DEF     : default opcodes used by the core's SPI master
//   - SPI_CPOL/CPHA : SPI mode served by the slave (mode 0)
// -----------------------------------------------------------------------------
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        DATA_RD,
        DATA_WR,
        IGNORE
    } state_e;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

    // Mode 0: clock idles low, data sampled on the rising edge and launched
    // on the falling edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_mem_slave_if.sv
// -----------------------------------------------------------------------------
// spi_mem_slave_if
//   Bundles the SPI pins, the preload port and the status outputs of the
//   SPI memory slave.
//   SPI pins   : spi_sclk_i, spi_mosi_i, spi_cs_i (active-low), spi_miso_o
//   Preload    : init_we_i, init_addr_i[AW-1:0], init_data_i[7:0]
//   Status     : busy_o, cmd_err_o (pulse), wr_strobe_o (pulse)
//   Modports   : slave  - the memory slave
//                master - the core / environment driving the slave
// -----------------------------------------------------------------------------
interface spi_mem_slave_if #(
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic          spi_sclk_i;
    logic          spi_mosi_i;
    logic          spi_cs_i;
    logic          spi_miso_o;
    logic          init_we_i;
    logic [AW-1:0] init_addr_i;
    logic [7:0]    init_data_i;
    logic          busy_o;
    logic          cmd_err_o;
    logic          wr_strobe_o;

    modport slave (
        input  spi_sclk_i, spi_mosi_i, spi_cs_i,
        input  init_we_i, init_addr_i, init_data_i,
        output spi_miso_o, busy_o, cmd_err_o, wr_strobe_o
    );

    modport master (
        output spi_sclk_i, spi_mosi_i, spi_cs_i,
        output init_we_i, init_addr_i, init_data_i,
        input  spi_miso_o, busy_o, cmd_err_o, wr_strobe_o
    );

endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   Two-flop synchronizer for an asynchronous SPI pin plus edge detection on
//   the synchronized level.
//   clk_core_i : system clock
//   rst_i      : synchronous active-high reset
//   din_i      : asynchronous input pin
//   dout_o     : synchronized level
//   rise_o     : one-cycle pulse, synchronized level went 0 -> 1
//   fall_o     : one-cycle pulse, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk_core_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: all three flops update together on one edge; non-blocking
    // assignments keep this a real 3-stage shift instead of collapsing it.
    always_ff @(posedge clk_core_i) begin
        if (rst_i) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din_i;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout_o = sync;
    assign rise_o = sync & ~prev;
    assign fall_o = ~sync & prev;

endmodule

// File: rtl/spi_mem_slave.sv
// -----------------------------------------------------------------------------
// spi_mem_slave
//   SPI mode-0 memory slave emulating the core's external instruction/data
//   memory. Frame: command byte, 16-bit address, then an unbounded burst of
//   data bytes. Reads stream mem[addr], mem[addr+1], ...; writes commit one
//   byte per completed SPI byte. Addresses wrap modulo DEPTH.
//   clk_core_i : system clock, all logic on the rising edge
//   rst_i      : synchronous active-high reset
//   bus        : spi_mem_slave_if.slave (SPI pins, preload port, status)
// -----------------------------------------------------------------------------
module spi_mem_slave
    import spi_mem_pkg::*;
#(
    parameter int         DEPTH     = 256,
    parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
    input  logic            clk_core_i,
    input  logic            rst_i,
    spi_mem_slave_if.slave  bus
);

    localparam int AW             = $clog2(DEPTH);
    localparam bit SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    typedef logic [AW-1:0] idx_t;

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_meta, mosi_sync;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk_core_i (clk_core_i),
        .rst_i      (rst_i),
        .din_i      (bus.spi_sclk_i),
        .dout_o     (sclk_sync),
        .rise_o     (sclk_rise),
        .fall_o     (sclk_fall)
    );

    // CS resets to the asserted level so that a CS already low when reset
    // releases produces no falling edge: a new frame needs CS high then low.
    spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
        .clk_core_i (clk_core_i),
        .rst_i      (rst_i),
        .din_i      (bus.spi_cs_i),
        .dout_o     (cs_sync),
        .rise_o     (cs_rise),
        .fall_o     (cs_fall)
    );

    // Same two-stage latency as sclk, so mosi_sync is aligned with sclk_rise.
    always_ff @(posedge clk_core_i) begin
        if (rst_i) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= bus.spi_mosi_i;
            mosi_sync <= mosi_meta;
        end
    end

    logic sample;
    logic launch;
    assign sample = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign launch = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    state_e      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic [15:0] addr_q;
    logic [7:0]  tx_shift;
    logic        rd_flag;
    logic        rd_pending;   // a data-phase sample edge has been seen

    assign rx_byte   = {rx_shift, mosi_sync};
    assign byte_done = sample && (bit_cnt == 3'd7);

    // ------------------------------------------------------------------
    // Memory: one write port (SPI or preload), one asynchronous read port
    // ------------------------------------------------------------------
    logic [7:0] mem [DEPTH];
    idx_t       rd_idx;
    logic [7:0] rd_data;
    logic       spi_wr_en;
    logic       init_wr_en;

    // First data byte is read at the address being completed; later bytes
    // look one ahead of the current address.
    assign rd_idx     = (state == ADDR_LO) ? idx_t'({addr_q[15:8], rx_byte})
                                           : idx_t'(addr_q + 16'd1);
    assign rd_data    = mem[rd_idx];
    assign spi_wr_en  = (state == DATA_WR) && byte_done && !cs_rise;
    assign init_wr_en = bus.init_we_i && (state == IDLE);

    // NOTE: the array has no reset; program images survive rst_i and the
    // storage maps onto plain RAM.
    always_ff @(posedge clk_core_i) begin
        if (spi_wr_en) begin
            mem[idx_t'(addr_q)] <= rx_byte;
        end else if (init_wr_en) begin
            mem[idx_t'(bus.init_addr_i)] <= bus.init_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_core_i) begin
        if (rst_i) begin
            state           <= IDLE;
            bit_cnt         <= 3'd0;
            rx_shift        <= 7'd0;
            addr_q          <= 16'd0;
            tx_shift        <= 8'd0;
            rd_flag         <= 1'b0;
            rd_pending      <= 1'b0;
            bus.spi_miso_o  <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.cmd_err_o   <= 1'b0;
            bus.wr_strobe_o <= 1'b0;
        end else begin
            bus.cmd_err_o   <= 1'b0;
            bus.wr_strobe_o <= 1'b0;
            bus.busy_o      <= !cs_sync && (state != IDLE);

            if ((state != IDLE) && cs_rise) begin
                // Abort: any partial byte is dropped with no side effect.
                state          <= IDLE;
                bit_cnt        <= 3'd0;
                rd_pending     <= 1'b0;
                bus.spi_miso_o <= 1'b0;
            end else begin
                if ((state != IDLE) && sample) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end

                case (state)
                    IDLE: begin
                        if (cs_fall && (sclk_sync == SPI_CPOL)) begin
                            state   <= CMD;
                            bit_cnt <= 3'd0;
                        end
                    end

                    CMD: begin
                        if (byte_done) begin
                            if (rx_byte == CMD_READ) begin
                                rd_flag <= 1'b1;
                                state   <= ADDR_HI;
                            end else if (rx_byte == CMD_WRITE) begin
                                rd_flag <= 1'b0;
                                state   <= ADDR_HI;
                            end else begin
                                bus.cmd_err_o <= 1'b1;
                                state         <= IGNORE;
                            end
                        end
                    end

                    ADDR_HI: begin
                        if (byte_done) begin
                            addr_q[15:8] <= rx_byte;
                            state        <= ADDR_LO;
                        end
                    end

                    ADDR_LO: begin
                        if (byte_done) begin
                            addr_q[7:0] <= rx_byte;
                            if (rd_flag) begin
                                // Present bit 7 before the first data-phase
                                // sample edge.
                                tx_shift       <= rd_data;
                                bus.spi_miso_o <= rd_data[7];
                                rd_pending     <= 1'b0;
                                state          <= DATA_RD;
                            end else begin
                                state <= DATA_WR;
                            end
                        end
                    end

                    DATA_RD: begin
                        // The launch edge right after the last address bit
                        // must not shift; only launch edges that follow a
                        // data-phase sample do.
                        if (sample) begin
                            rd_pending <= 1'b1;
                        end else if (launch && rd_pending) begin
                            rd_pending <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                addr_q         <= addr_q + 16'd1;
                                tx_shift       <= rd_data;
                                bus.spi_miso_o <= rd_data[7];
                            end else begin
                                tx_shift       <= {tx_shift[6:0], 1'b0};
                                bus.spi_miso_o <= tx_shift[6];
                            end
                        end
                    end

                    DATA_WR: begin
                        if (byte_done) begin
                            bus.wr_strobe_o <= 1'b1;
                            addr_q          <= addr_q + 16'd1;
                        end
                    end

                    IGNORE: begin
                        bus.spi_miso_o <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_slave
//   Directed bench for spi_mem_slave. The stimulus side drives SPI frames and
//   pushes the MISO byte expected for every complete byte of each frame; a
//   bus monitor collects MISO on each SCLK rise and compares against the
//   queue. Strobe pulses are counted on the opposite clock edge.
// -----------------------------------------------------------------------------
module tb_spi_mem_slave;

    localparam int DEPTH = 256;
    localparam int HALF  = 4;     // SCLK half period in core clocks

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_mem_slave_if #(.DEPTH(DEPTH)) bus ();

    spi_mem_slave #(.DEPTH(DEPTH)) dut (
        .clk_core_i (clk),
        .rst_i      (rst),
        .bus        (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb_q [$];
    logic [7:0] tq [$];
    logic [7:0] eq [$];
    logic       exp_busy = 1'b1;
    int         wr_pulses = 0;
    int         err_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.wr_strobe_o === 1'b1) wr_pulses++;
        if (bus.cmd_err_o === 1'b1)   err_pulses++;
    end

    // Bus monitor / scoreboard checker.
    initial begin : monitor
        logic [7:0] sh;
        logic [7:0] exp;
        int         nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge bus.spi_sclk_i or posedge bus.spi_cs_i);
            if (bus.spi_cs_i === 1'b1) begin
                nb = 0;
            end else begin
                sh = {sh[6:0], bus.spi_miso_o};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL miso_unexpected: got 0x%0h, expected no byte", sh);
                    end else begin
                        exp = sb_q.pop_front();
                        check("miso_byte", sh, exp);
                        check("busy_in_xfer", bus.busy_o, exp_busy);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_mosi_i = b[i];
            wait_clk(HALF);
            bus.spi_sclk_i = 1'b1;
            wait_clk(HALF);
            bus.spi_sclk_i = 1'b0;
        end
    endtask

    task automatic cs_on();
        wait_clk(1);
        bus.spi_cs_i = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_off();
        wait_clk(HALF);
        bus.spi_cs_i = 1'b1;
        wait_clk(3 * HALF);
    endtask

    // Full frame from tq; expected MISO bytes from eq.
    task automatic xfer();
        foreach (eq[i]) sb_q.push_back(eq[i]);
        cs_on();
        foreach (tq[i]) spi_bits(tq[i], 8);
        cs_off();
    endtask

    task automatic init_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.init_we_i   = 1'b1;
        bus.init_addr_i = a;
        bus.init_data_i = d;
        @(negedge clk);
        bus.init_we_i   = 1'b0;
    endtask

    int w0;
    int e0;

    initial begin
        bus.spi_sclk_i  = 1'b0;
        bus.spi_mosi_i  = 1'b0;
        bus.spi_cs_i    = 1'b1;
        bus.init_we_i   = 1'b0;
        bus.init_addr_i = '0;
        bus.init_data_i = 8'h00;

        // Reset state
        wait_clk(5);
        check("rst_miso", bus.spi_miso_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_cmd_err", bus.cmd_err_o, 1'b0);
        check("rst_wr_strobe", bus.wr_strobe_o, 1'b0);
        rst = 1'b0;
        wait_clk(6);

        init_wr(8'h10, 8'hA5);
        init_wr(8'h11, 8'h3C);
        init_wr(8'h30, 8'hC3);
        init_wr(8'h40, 8'h12);
        init_wr(8'h41, 8'h34);

        // Two-byte read of preloaded data
        tq = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00};
        eq = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h3C};
        xfer();

        // Single write, then read back
        w0 = wr_pulses;
        tq = '{8'h02, 8'h00, 8'h20, 8'h5A};
        eq = '{8'h00, 8'h00, 8'h00, 8'h00};
        xfer();
        check("wr_strobe_single", wr_pulses - w0, 1);
        tq = '{8'h03, 8'h00, 8'h20, 8'h00};
        eq = '{8'h00, 8'h00, 8'h00, 8'h5A};
        xfer();

        // Write burst wrapping 0xFF -> 0x00, then read burst across the wrap
        w0 = wr_pulses;
        tq = '{8'h02, 8'h00, 8'hFF, 8'h11, 8'h22};
        eq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        xfer();
        check("wr_strobe_wrap", wr_pulses - w0, 2);
        tq = '{8'h03, 8'h00, 8'hFF, 8'h00, 8'h00};
        eq = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        xfer();

        // Unknown opcode
        w0 = wr_pulses;
        e0 = err_pulses;
        tq = '{8'h9F, 8'h00, 8'h10, 8'h77};
        eq = '{8'h00, 8'h00, 8'h00, 8'h00};
        xfer();
        check("cmd_err_pulse", err_pulses - e0, 1);
        check("cmd_err_no_write", wr_pulses - w0, 0);
        tq = '{8'h03, 8'h00, 8'h10, 8'h00};
        eq = '{8'h00, 8'h00, 8'h00, 8'hA5};
        xfer();

        // Aborted partial data byte
        w0 = wr_pulses;
        eq = '{8'h00, 8'h00, 8'h00};
        foreach (eq[i]) sb_q.push_back(eq[i]);
        cs_on();
        spi_bits(8'h02, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'h30, 8);
        spi_bits(8'hFF, 5);
        cs_off();
        check("partial_no_strobe", wr_pulses - w0, 0);
        tq = '{8'h03, 8'h00, 8'h30, 8'h00};
        eq = '{8'h00, 8'h00, 8'h00, 8'hC3};
        xfer();

        // Preload during an active read is ignored
        eq = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h34};
        foreach (eq[i]) sb_q.push_back(eq[i]);
        cs_on();
        spi_bits(8'h03, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'h40, 8);
        wait_clk(2);
        init_wr(8'h41, 8'h77);
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 8);
        cs_off();
        init_wr(8'h41, 8'h77);
        tq = '{8'h03, 8'h00, 8'h41, 8'h00};
        eq = '{8'h00, 8'h00, 8'h00, 8'h77};
        xfer();

        // Reset in the middle of a read: first 3 bits of 0xA5, then zeros
        eq = '{8'h00, 8'h00, 8'h00, 8'hA0};
        foreach (eq[i]) sb_q.push_back(eq[i]);
        cs_on();
        spi_bits(8'h03, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'h10, 8);
        spi_bits(8'h00, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_miso", bus.spi_miso_o, 1'b0);
        check("midrst_busy", bus.busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_busy = 1'b0;
        spi_bits(8'h00, 5);
        cs_off();
        exp_busy = 1'b1;
        tq = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00};
        eq = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h3C};
        xfer();

        wait_clk(4);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_mem_slave.md
Name: spi_mem_slave

Overview:
- Synthesizable SPI memory slave on the far side of the core SPI pins (spi_sclk/spi_mosi/spi_cs/spi_miso); emulates the external instruction/data memory for FPGA bring-up and full-chip simulation.
- Decodes the core's SPI master framing: command byte, 16-bit address, 1..N data bytes.
- Serves reads from, and commits writes to, an internal byte array.
- A parallel init port preloads program images while the bus is idle.

Parameters:
- DEPTH, 256, bytes of storage; power of two; address uses the low log2(DEPTH) bits, upper bits ignored.
- CMD_READ, 8'h03, read opcode.
- CMD_WRITE, 8'h02, write opcode.

Ports:
- clk_core_i  in  1  system clock; single clock domain, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- spi_sclk_i  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0)
- spi_mosi_i  in  1  master-out data, MSB first
- spi_cs_i  in  1  chip select, active-low
- spi_miso_o  out  1  slave-out data, MSB first
- init_we_i  in  1  preload write strobe
- init_addr_i  in  log2(DEPTH)  preload address
- init_data_i  in  8  preload data
- busy_o  out  1  high while CS is asserted (synchronized)
- cmd_err_o  out  1  one-cycle pulse on an unknown opcode
- wr_strobe_o  out  1  one-cycle pulse per SPI byte committed to memory

Behaviour:
- Input sync: sclk, mosi, cs each pass through 2 flops. Edges are detected on the synchronized sclk (rise = sampled 0 then 1).
- Timing requirement: the SCLK high and low phases are each at least 4 clk_core_i cycles. The master's CLOCK_DIVIDER=4 satisfies this.
- Reset: state IDLE, bit_cnt=0, addr=0, spi_miso_o=0, busy_o=0, cmd_err_o=0, wr_strobe_o=0. Memory contents are not cleared.
- Bit counter: 3 bits. MOSI is shifted in on each sclk rise. A byte completes when bit_cnt wraps 7->0.
- FSM:
  - IDLE: wait for synchronized cs low -> CMD, bit_cnt=0.
  - CMD: on byte complete, byte==CMD_READ -> ADDR_HI (rd flag=1); byte==CMD_WRITE -> ADDR_HI (rd flag=0); any other value -> pulse cmd_err_o, go to IGNORE.
  - ADDR_HI: on byte complete, store addr[15:8] (discarded if DEPTH<=256) -> ADDR_LO.
  - ADDR_LO: on byte complete, addr = byte. If rd flag: load tx_shift=mem[addr] in the same cycle -> DATA_RD. Else -> DATA_WR.
  - DATA_RD: spi_miso_o = tx_shift[7] and updates only on sclk fall (shift left). The first data bit is valid before the first data-phase rise. After the 8th fall of a byte: addr++ (wraps modulo DEPTH), reload tx_shift=mem[addr]. Unbounded burst.
  - DATA_WR: on byte complete, mem[addr]<=byte, pulse wr_strobe_o, then addr++ with wrap. Bits arriving before CS rises that do not complete a byte are discarded and nothing is written.
  - IGNORE: spi_miso_o=0; wait for CS high.
- CS deassert (synchronized cs goes high) in any state: return to IDLE next cycle, bit_cnt=0, spi_miso_o=0. An aborted partial byte has no memory side effect.
- spi_miso_o is held 0 whenever not in DATA_RD. There is no tristate inside the block.
- Init port: init_we_i writes mem[init_addr_i] only when the FSM is in IDLE. It is ignored otherwise, because the SPI path owns the array during a transaction.
- Simultaneous reset and CS activity: reset wins; the FSM stays in IDLE until CS is seen high and then low again.
- Memory: single array, one write port (SPI or init, muxed), one asynchronous or registered read. A registered read must still meet the first-fall deadline; at least 2 cycles of margin exist.

Decomposition:
- Package spi_mem_pkg: state enum (IDLE, CMD, ADDR_HI, ADDR_LO, DATA_RD, DATA_WR, IGNORE), CMD_READ/CMD_WRITE default constants, SPI mode constants.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall detector, instantiated for sclk and cs. mosi uses a plain synchronizer.

Test Plan:
- Preload mem[0x10]=0xA5 and mem[0x11]=0x3C via init; SPI read 03 00 10 with 2 data bytes -> MISO returns 0xA5 then 0x3C; busy_o high throughout the transaction.
- SPI write 02 00 20 5A -> wr_strobe_o pulses once; a subsequent read of 0x20 returns 0x5A.
- With DEPTH=256: write 02 00 FF 11 22 -> mem[0xFF]=0x11 and mem[0x00]=0x22 (wrap-around); two wr_strobe_o pulses.
- Opcode 0x9F -> cmd_err_o pulses 1 cycle; MISO stays 0 for the remaining 24 clocks; memory unchanged.
- Write 02 00 30 followed by 5 bits, then CS high -> mem[0x30] unchanged; no wr_strobe_o; the next full transaction works normally.
- init_we_i asserted during an active read -> memory not modified; the same init write issued after CS high takes effect. Assert rst_i mid-read -> spi_miso_o=0 and FSM in IDLE on the next cycle.
